// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: memory funct3 codes and LSU state encodings.
package riscv_lsu_pkg;

    localparam logic [2:0] FUNCT3_MEM_B  = 3'b000;
    localparam logic [2:0] FUNCT3_MEM_H  = 3'b001;
    localparam logic [2:0] FUNCT3_MEM_W  = 3'b010;
    localparam logic [2:0] FUNCT3_MEM_BU = 3'b100;
    localparam logic [2:0] FUNCT3_MEM_HU = 3'b101;

    localparam logic [1:0] LSU_ST_IDLE   = 2'd0;
    localparam logic [1:0] LSU_ST_ACCESS = 2'd1;
    localparam logic [1:0] LSU_ST_DONE   = 2'd2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } lsu_size_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extraction and legality check.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic        wr_en_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    lsu_size_e   size;
    logic [31:0] shifted;

    always_comb begin
        size      = lsu_size_e'(funct3_i[1:0]);
        shifted   = rdata_i >> {addr_lo_i, 3'b000};
        byte_en_o = 4'b0000;
        wdata_o   = wdata_i;
        rdata_o   = shifted;
        err_o     = 1'b0;
        case (size)
            SZ_BYTE: begin
                byte_en_o = 4'b0001 << addr_lo_i;
                wdata_o   = {4{wdata_i[7:0]}};
                rdata_o   = funct3_i[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                byte_en_o = 4'b0011 << addr_lo_i;
                wdata_o   = {2{wdata_i[15:0]}};
                rdata_o   = funct3_i[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
                err_o     = addr_lo_i[0];
            end
            SZ_WORD: begin
                byte_en_o = 4'b1111;
                err_o     = (addr_lo_i != 2'b00) || funct3_i[2];
            end
            default: err_o = 1'b1;
        endcase
        // Stores have no unsigned variants.
        if (wr_en_i && funct3_i[2]) begin
            err_o = 1'b1;
        end
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: accepts one core request, runs a req/ack data-memory access, returns extended load data.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_CNT_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_lsu_valid,
    output logic        o_lsu_ready,
    input  logic        i_lsu_wr_en,
    input  logic [2:0]  i_lsu_funct3,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_lsu_wdata,
    output logic        o_lsu_done,
    output logic        o_lsu_err,
    output logic [31:0] o_lsu_rdata,
    output logic        o_dmem_req,
    output logic        o_dmem_wr_en,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_byte_en,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata
);

    // state  | meaning
    // IDLE   | ready, waiting for a core request
    // ACCESS | memory request outstanding, counting wait cycles
    // DONE   | one-cycle completion pulse

    localparam logic [TO_CNT_W-1:0] TO_LAST =
        TO_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]          state_q, state_d;
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    logic                wr_en_q, wr_en_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;

    logic        in_idle;
    logic        in_access;
    logic [3:0]  al_byte_en;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_err;

    assign in_idle   = (state_q == LSU_ST_IDLE);
    assign in_access = (state_q == LSU_ST_ACCESS);

    // In IDLE the checker sees the incoming request; afterwards it sees the latched one.
    riscv_lsu_align u_align (
        .wr_en_i   (in_idle ? i_lsu_wr_en       : wr_en_q),
        .funct3_i  (in_idle ? i_lsu_funct3      : funct3_q),
        .addr_lo_i (in_idle ? i_lsu_addr[1:0]   : addr_q[1:0]),
        .wdata_i   (in_idle ? i_lsu_wdata       : wdata_q),
        .rdata_i   (i_dmem_rdata),
        .byte_en_o (al_byte_en),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata),
        .err_o     (al_err)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_en_d  = wr_en_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        case (state_q)
            LSU_ST_IDLE: begin
                if (i_lsu_valid) begin
                    wr_en_d  = i_lsu_wr_en;
                    funct3_d = i_lsu_funct3;
                    addr_d   = i_lsu_addr;
                    wdata_d  = i_lsu_wdata;
                    err_d    = al_err;
                    cnt_d    = '0;
                    state_d  = al_err ? LSU_ST_DONE : LSU_ST_ACCESS;
                end
            end
            LSU_ST_ACCESS: begin
                if (i_dmem_ack) begin
                    state_d = LSU_ST_DONE;
                    if (!wr_en_q) begin
                        rdata_d = al_rdata;
                    end
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                    state_d = LSU_ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_CNT_W'(1);
                end
            end
            LSU_ST_DONE: state_d = LSU_ST_IDLE;
            default:     state_d = LSU_ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= LSU_ST_IDLE;
            cnt_q    <= '0;
            wr_en_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_en_q  <= wr_en_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign o_lsu_ready    = in_idle;
    assign o_lsu_done     = (state_q == LSU_ST_DONE);
    assign o_lsu_err      = err_q;
    assign o_lsu_rdata    = rdata_q;
    assign o_dmem_req     = in_access;
    assign o_dmem_wr_en   = in_access & wr_en_q;
    assign o_dmem_addr    = in_access ? {addr_q[31:2], 2'b00} : 32'b0;
    assign o_dmem_byte_en = in_access ? al_byte_en : 4'b0000;
    assign o_dmem_wdata   = in_access ? al_wdata : 32'b0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized self-checking bench for riscv_lsu against a byte-level reference model.
module tb_riscv_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_wr_en;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic        lsu_err;
    logic [31:0] lsu_rdata;
    logic        dmem_req;
    logic        dmem_wr_en;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_byte_en;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_rdata = 32'b0;

    always #5 clk = ~clk;

    riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_lsu_valid    (lsu_valid),
        .o_lsu_ready    (lsu_ready),
        .i_lsu_wr_en    (lsu_wr_en),
        .i_lsu_funct3   (lsu_funct3),
        .i_lsu_addr     (lsu_addr),
        .i_lsu_wdata    (lsu_wdata),
        .o_lsu_done     (lsu_done),
        .o_lsu_err      (lsu_err),
        .o_lsu_rdata    (lsu_rdata),
        .o_dmem_req     (dmem_req),
        .o_dmem_wr_en   (dmem_wr_en),
        .o_dmem_addr    (dmem_addr),
        .o_dmem_byte_en (dmem_byte_en),
        .o_dmem_wdata   (dmem_wdata),
        .i_dmem_ack     (dmem_ack),
        .i_dmem_rdata   (dmem_rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Access size in bytes decides everything: lanes, alignment, replication and extension.
    function automatic void ref_model(input bit wr, input bit [2:0] f3, input bit [31:0] addr,
                                      input bit [31:0] wdata, input bit [31:0] rdata,
                                      output bit err, output bit [3:0] be,
                                      output bit [31:0] wrep, output bit [31:0] rext);
        int     nbytes;
        int     off;
        bit     uns;
        longint mask;
        longint val;
        off    = int'(addr % 4);
        uns    = f3[2];
        case (f3 % 4)
            0:       nbytes = 1;
            1:       nbytes = 2;
            2:       nbytes = 4;
            default: nbytes = 0;
        endcase
        err = (nbytes == 0) || (uns && (wr || nbytes == 4));
        if (nbytes != 0 && (off % nbytes) != 0) err = 1'b1;
        be   = 4'(((1 << nbytes) - 1) << off);
        wrep = 32'b0;
        for (int i = 0; i < 4; i++) begin
            if (nbytes != 0) wrep[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
        end
        mask = (64'd1 << (8 * nbytes)) - 1;
        val  = (longint'(rdata) >> (8 * off)) & mask;
        if (!uns && nbytes != 0 && val[8*nbytes-1]) val = val | ~mask;
        rext = val[31:0];
    endfunction

    // waits = idle ACCESS cycles before the ack; waits >= TO never acks.
    task automatic run_txn(input string tag, input bit wr, input bit [2:0] f3, input bit [31:0] addr,
                           input bit [31:0] wdata, input bit [31:0] rdata, input int waits);
        bit        m_err;
        bit [3:0]  m_be;
        bit [31:0] m_wrep;
        bit [31:0] m_rext;
        bit        exp_err;
        int        exp_lat;
        int        exp_reqs;
        int        lat;
        int        reqs;
        bit        seen_done;
        ref_model(wr, f3, addr, wdata, rdata, m_err, m_be, m_wrep, m_rext);
        exp_err  = m_err || (waits >= TO);
        exp_lat  = m_err ? 1 : (waits >= TO) ? TO + 1 : waits + 2;
        exp_reqs = m_err ? 0 : (waits >= TO) ? TO : waits + 1;
        lat       = 0;
        reqs      = 0;
        seen_done = 1'b0;
        check_val({tag, ".ready"}, 32'(lsu_ready), 32'd1);
        lsu_wr_en  = wr;
        lsu_funct3 = f3;
        lsu_addr   = addr;
        lsu_wdata  = wdata;
        lsu_valid  = 1'b1;
        @(posedge clk);
        #1 lsu_valid = 1'b0;
        for (int c = 1; c <= 12 && !seen_done; c++) begin
            @(negedge clk);
            dmem_ack = 1'b0;
            if (lsu_done) begin
                seen_done = 1'b1;
                lat       = c;
            end else if (dmem_req) begin
                reqs++;
                if (reqs == 1) begin
                    check_val({tag, ".addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
                    check_val({tag, ".be"}, 32'(dmem_byte_en), 32'(m_be));
                    check_val({tag, ".we"}, 32'(dmem_wr_en), 32'(wr));
                    if (wr) check_val({tag, ".wdata"}, dmem_wdata, m_wrep);
                end
                if (reqs == waits + 1) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end else begin
                    dmem_rdata = $urandom;
                end
            end
        end
        dmem_ack = 1'b0;
        check_val({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        if (seen_done) begin
            if (!wr && !exp_err) model_rdata = m_rext;
            check_val({tag, ".err"}, 32'(lsu_err), 32'(exp_err));
            check_val({tag, ".reqs"}, 32'(reqs), 32'(exp_reqs));
            check_val({tag, ".rdata"}, lsu_rdata, model_rdata);
            @(negedge clk);
            check_val({tag, ".done_pulse"}, 32'(lsu_done), 32'd0);
        end
    endtask

    initial begin
        bit        wr;
        bit [2:0]  f3;
        bit [31:0] addr;
        int        waits;
        rst        = 1'b1;
        lsu_valid  = 1'b0;
        lsu_wr_en  = 1'b0;
        lsu_funct3 = 3'b000;
        lsu_addr   = 32'b0;
        lsu_wdata  = 32'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'b0;
        repeat (2) @(negedge clk);
        check_val("rst.ready", 32'(lsu_ready), 32'd1);
        check_val("rst.req", 32'(dmem_req), 32'd0);
        check_val("rst.done", 32'(lsu_done), 32'd0);
        check_val("rst.err", 32'(lsu_err), 32'd0);
        check_val("rst.rdata", lsu_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_txn("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        run_txn("sb", 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1);
        run_txn("lb", 1'b0, 3'b000, 32'h102, 32'h0, 32'h0080FF11, 0);
        check_val("lb.const", lsu_rdata, 32'hFFFFFF80);
        run_txn("lbu", 1'b0, 3'b100, 32'h102, 32'h0, 32'h0080FF11, 2);
        check_val("lbu.const", lsu_rdata, 32'h00000080);
        run_txn("lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80001234, 0);
        check_val("lh.const", lsu_rdata, 32'hFFFF8000);
        run_txn("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
        check_val("lw_mis.err", 32'(lsu_err), 32'd1);
        run_txn("st_f3", 1'b1, 3'b011, 32'h200, 32'h1234, 32'h0, 0);
        run_txn("sw_to", 1'b1, 3'b010, 32'h300, 32'h55AA55AA, 32'h0, TO);
        run_txn("sw_ack4", 1'b1, 3'b010, 32'h300, 32'h55AA55AA, 32'h0, TO - 1);
        run_txn("lw_to", 1'b0, 3'b010, 32'h304, 32'h0, 32'h12345678, TO);
        check_val("lw_to.keep", lsu_rdata, 32'hFFFF8000);

        for (int n = 0; n < 80; n++) begin
            wr    = 1'($urandom % 2);
            f3    = 3'($urandom % 8);
            addr  = $urandom;
            waits = $urandom_range(0, 5);
            run_txn("rand", wr, f3, addr, $urandom, $urandom, waits);
        end

        // Reset in the middle of an access.
        lsu_wr_en  = 1'b1;
        lsu_funct3 = 3'b010;
        lsu_addr   = 32'h400;
        lsu_wdata  = 32'hCAFEF00D;
        lsu_valid  = 1'b1;
        @(posedge clk);
        #1 lsu_valid = 1'b0;
        @(negedge clk);
        check_val("mid.req_before", 32'(dmem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("mid.req_async", 32'(dmem_req), 32'd0);
        check_val("mid.ready_async", 32'(lsu_ready), 32'd1);
        @(negedge clk);
        rst         = 1'b0;
        model_rdata = 32'b0;
        dmem_ack    = 1'b1;
        dmem_rdata  = 32'hFFFFFFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("stale.done", 32'(lsu_done), 32'd0);
            check_val("stale.ready", 32'(lsu_ready), 32'd1);
            check_val("stale.req", 32'(dmem_req), 32'd0);
        end
        dmem_ack = 1'b0;
        check_val("stale.rdata", lsu_rdata, model_rdata);
        run_txn("post_rst_lhu", 1'b0, 3'b101, 32'h502, 32'h0, 32'hBEEF0000, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit for the multicycle RV32I core; the execution end of the memory-control outputs produced by instruction decode (mem write enable, funct3 width/sign, byte select).
- Accepts one load/store per request from the core FSM, checks alignment, and drives a word-addressed data memory with a req/ack handshake.
- Generates byte enables and lane-replicated store data, and returns sign- or zero-extended load data.
- Sits between the core datapath (ALU address, rs2 data) and the data memory.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles waiting for i_dmem_ack before error; 0 disables timeout.
- TO_CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the wait counter (derived).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_lsu_valid  in  1  core request valid.
- o_lsu_ready  out  1  LSU idle, can accept a request.
- i_lsu_wr_en  in  1  1 = store, 0 = load.
- i_lsu_funct3  in  3  FUNCT3_MEM_* width/sign code.
- i_lsu_addr  in  32  byte address.
- i_lsu_wdata  in  32  store data (rs2).
- o_lsu_done  out  1  one-cycle completion pulse.
- o_lsu_err  out  1  misaligned, illegal funct3, or timeout; valid with done.
- o_lsu_rdata  out  32  extended load data; valid with done.
- o_dmem_req  out  1  memory request.
- o_dmem_wr_en  out  1  memory write.
- o_dmem_addr  out  32  word address, {addr[31:2],2'b00}.
- o_dmem_byte_en  out  4  active byte lanes.
- o_dmem_wdata  out  32  lane-replicated store data.
- i_dmem_ack  in  1  memory completion; read data valid this cycle.
- i_dmem_rdata  in  32  memory read word.

Behaviour:
- Reset (async, i_rst=1): state IDLE; all outputs 0 except o_lsu_ready=1; wait counter and captured request cleared. Reset mid-transaction aborts immediately, and o_dmem_req drops with reset.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: o_lsu_ready=1. When i_lsu_valid=1, latch wr_en, funct3, addr and wdata.
  - Error case goes to DONE with err=1 and no memory access. The error case is any of: half access with addr[0]=1; word access with addr[1:0]!=0; load funct3 in {3,6,7}; store funct3 >2.
  - Otherwise go to ACCESS.
- ACCESS:
  - o_dmem_req=1. o_dmem_addr, wr_en, byte_en and wdata come from latched values and stay stable until ack.
  - The wait counter increments each cycle without ack.
  - On i_dmem_ack=1, go to DONE. For a load, register the extracted word into o_lsu_rdata in the same edge.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without ack, go to DONE with err=1. Ack in that same cycle wins: no error.
- DONE: o_lsu_done=1 for exactly one cycle, o_lsu_ready=0, then go to IDLE.
- Latency: with accept at edge 0 and ack in the first ACCESS cycle, done is high in the cycle after edge 1, i.e. 2 cycles after accept. Each wait cycle adds 1. A misaligned or illegal request completes in 1 cycle.
- Byte enables:
  - byte: 4'b0001<<addr[1:0].
  - half: 4'b0011<<addr[1:0].
  - word: 4'b1111.
  - Loads drive the same enables.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: as-is.
- Load extraction: shifted = rdata >> (8*addr[1:0]).
  - LB: sign-extend [7:0]. LBU: zero-extend [7:0].
  - LH: sign-extend [15:0]. LHU: zero-extend [15:0].
  - LW: full word.
- o_lsu_rdata holds its value until the next load completes. Stores and errors leave it unchanged.
- o_lsu_err is cleared on the next accepted request.
- i_dmem_ack outside ACCESS is ignored.
- i_lsu_valid while not ready is ignored; the core must hold it.

Decomposition:
- Shared configs header: FUNCT3_MEM_* codes (existing) plus new LSU_ST_IDLE/ACCESS/DONE encodings.
- One combinational sub-module, riscv_lsu_align: funct3 + addr[1:0] + wdata + rdata -> byte_en, replicated wdata, extended rdata, misalign/illegal flag.
- The FSM, counter and registers stay in riscv_lsu.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ack in first ACCESS cycle -> dmem_addr=0x100, byte_en=1111, wdata=0xDEADBEEF; done 2 cycles after accept; err=0.
- SB addr=0x103, wdata=0x000000A5 -> byte_en=1000, dmem_wdata=0xA5A5A5A5, dmem_addr=0x100.
- LB addr=0x102, rdata=0x0080FF11 -> rdata=0xFFFFFF80. LBU with the same inputs -> 0x00000080. LH addr=0x102, rdata=0x80001234 -> 0xFFFF8000.
- LW addr=0x101 -> no dmem_req; done next cycle with err=1. Store funct3=3'b011 -> err=1.
- TIMEOUT_CYCLES=4, ack never asserted -> req held 4 cycles, then done with err=1. Repeat with ack on the 4th cycle -> err=0.
- Assert i_rst during ACCESS -> o_dmem_req=0 asynchronously, ready=1 after release; a stale ack after reset produces no done.
